// File: rtl/cp0_pkg.sv
// Shared definitions for the nested CP0 interrupt controller: register
// addresses, Status bit positions and a width helper.
package cp0_pkg;

   localparam logic [1:0] CP0_STATUS = 2'd0;
   localparam logic [1:0] CP0_MASK   = 2'd1;
   localparam logic [1:0] CP0_EPC    = 2'd2;
   localparam logic [1:0] CP0_CAUSE  = 2'd3;

   localparam int STATUS_IE_BIT = 0;

   // Ceiling log2, used to size index and level fields.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cp0_nest_ctrl_if.sv
// CP register access port (mfc0/mtc0) between the pipeline and CP0.
interface cp0_nest_ctrl_if #(
   parameter int DATA_W = 32
) ();

   logic              in_cp_we;
   logic [1:0]        in_cp_addr;
   logic [DATA_W-1:0] in_cp_wdata;
   logic [DATA_W-1:0] out_cp_rdata;

   modport master (
      output in_cp_we,
      output in_cp_addr,
      output in_cp_wdata,
      input  out_cp_rdata
   );

   modport slave (
      input  in_cp_we,
      input  in_cp_addr,
      input  in_cp_wdata,
      output out_cp_rdata
   );

endinterface

// File: rtl/cp0_prio_enc.sv
// Lowest-index-first priority encoder returning {valid, index}.
module cp0_prio_enc #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   // Scan from the top down so the lowest set index is the one that sticks.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/cp0_nest_ctrl.sv
// Coprocessor-0 interrupt controller with nested interrupts: Status/Mask/
// EPC/Cause registers, priority qualification and an EPC/in-service stack.
module cp0_nest_ctrl
   import cp0_pkg::*;
#(
   parameter int  DATA_W     = 32,
   parameter int  NUM_IRQ    = 4,
   parameter int  NEST_DEPTH = 4,
   localparam int VEC_W      = (clog2(NUM_IRQ) < 1) ? 1 : clog2(NUM_IRQ),
   localparam int LVL_W      = clog2(NEST_DEPTH) + 1
) (
   input  logic               in_clk,
   input  logic               in_RST,
   input  logic [NUM_IRQ-1:0] in_irq,
   input  logic [DATA_W-1:0]  in_WB_PC,
   input  logic               in_eret,
   cp0_nest_ctrl_if.slave     cp,
   output logic               out_take,
   output logic [VEC_W-1:0]   out_vector,
   output logic [DATA_W-1:0]  out_EPC,
   output logic               out_IE,
   output logic [NUM_IRQ-1:0] out_INM,
   output logic [LVL_W-1:0]   out_level,
   output logic               out_err
);

   localparam int PTR_W = (clog2(NEST_DEPTH) < 1) ? 1 : clog2(NEST_DEPTH);

   logic               ie;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] inm;
   logic [LVL_W-1:0]   level;
   logic [DATA_W-1:0]  stack [NEST_DEPTH];
   logic               take;
   logic [VEC_W-1:0]   vector;
   logic               err;

   logic [NUM_IRQ-1:0] pend;
   logic               pend_vld;
   logic [VEC_W-1:0]   cand;
   logic               inm_vld;
   logic [VEC_W-1:0]   hs;
   logic               empty;
   logic               full;
   logic               eligible;
   logic [PTR_W-1:0]   top_ptr;
   logic [PTR_W-1:0]   push_ptr;
   logic [DATA_W-1:0]  epc;

   assign pend     = in_irq & mask;
   assign empty    = (level == '0);
   assign full     = (level == LVL_W'(NEST_DEPTH));
   assign top_ptr  = PTR_W'(level - LVL_W'(1));
   assign push_ptr = PTR_W'(level);
   assign epc      = empty ? '0 : stack[top_ptr];

   cp0_prio_enc #(.N(NUM_IRQ), .IDX_W(VEC_W)) u_pend_enc (
      .req   (pend),
      .valid (pend_vld),
      .index (cand)
   );

   cp0_prio_enc #(.N(NUM_IRQ), .IDX_W(VEC_W)) u_inm_enc (
      .req   (inm),
      .valid (inm_vld),
      .index (hs)
   );

   // A request may pre-empt only a strictly lower-priority handler in service.
   assign eligible = ie & pend_vld & ~full & (~inm_vld | (cand < hs));

   // Combinational CP register read; Cause reflects live masked requests.
   always_comb begin
      cp.out_cp_rdata = '0;
      case (cp.in_cp_addr)
         CP0_STATUS: cp.out_cp_rdata[STATUS_IE_BIT] = ie;
         CP0_MASK:   cp.out_cp_rdata[NUM_IRQ-1:0]   = mask;
         CP0_EPC:    cp.out_cp_rdata                = epc;
         default:    cp.out_cp_rdata[NUM_IRQ-1:0]   = pend;
      endcase
   end

   // Register state: eret beats take, take beats Status/EPC writes; Mask writes always land.
   always_ff @(posedge in_clk) begin
      if (in_RST) begin
         ie     <= 1'b0;
         mask   <= '0;
         inm    <= '0;
         level  <= '0;
         take   <= 1'b0;
         vector <= '0;
         err    <= 1'b0;
         for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
      end else begin
         take <= 1'b0;
         if (cp.in_cp_we && cp.in_cp_addr == CP0_MASK)
            mask <= cp.in_cp_wdata[NUM_IRQ-1:0];
         if (in_eret) begin
            if (!empty) begin
               level <= level - LVL_W'(1);
               inm   <= inm & ~(NUM_IRQ'(1) << hs);
               ie    <= 1'b1;
            end else begin
               err <= 1'b1;
            end
         end else if (eligible) begin
            stack[push_ptr] <= in_WB_PC;
            level           <= level + LVL_W'(1);
            inm             <= inm | (NUM_IRQ'(1) << cand);
            ie              <= 1'b0;
            take            <= 1'b1;
            vector          <= cand;
         end else if (cp.in_cp_we) begin
            if (cp.in_cp_addr == CP0_STATUS)
               ie <= cp.in_cp_wdata[STATUS_IE_BIT];
            if (cp.in_cp_addr == CP0_EPC && !empty)
               stack[top_ptr] <= cp.in_cp_wdata;
         end
      end
   end

   assign out_take   = take;
   assign out_vector = vector;
   assign out_EPC    = epc;
   assign out_IE     = ie;
   assign out_INM    = inm;
   assign out_level  = level;
   assign out_err    = err;

endmodule
